// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    // Requester identifiers
    typedef enum logic [1:0] {
        PortIf = 2'd0,
        PortD  = 2'd1,
        PortX  = 2'd2
    } port_id_e;

    // Byte enables for a full-word access
    localparam logic [3:0] BeWord = 4'b1111;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane steering between a requester and the 32-bit memory word.
// Word accesses pass straight through; byte accesses replicate the store
// byte onto every lane and sign-extend the selected lane on loads.
module mem_lane_fmt
    import mem_arb_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        bmode,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] lane_rdata
);

    logic [7:0] sel_byte;

    // Select enables, store data and load data for the current access width
    always_comb begin
        sel_byte   = mem_rdata[{lane, 3'b000} +: 8];
        be         = BeWord;
        lane_wdata = wdata;
        lane_rdata = mem_rdata;
        if (bmode) begin
            be         = 4'b0001 << lane;
            lane_wdata = {4{wdata[7:0]}};
            lane_rdata = {{24{sel_byte[7]}}, sel_byte};
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF), data (D)
// and an external DMA/debug port (X). One access at a time: IDLE arbitrates
// and latches the winner, ACCESS drives the memory for WAIT+1 cycles, RESP
// pulses the winner's ack for one cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW   = 10,
    parameter int unsigned WAIT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ack,

    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_bmode,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ack,
    output logic          d_err,

    input  logic          x_req,
    input  logic          x_we,
    input  logic [31:0]   x_addr,
    input  logic [31:0]   x_wdata,
    output logic [31:0]   x_rdata,
    output logic          x_ack,

    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [3:0] WaitInit = 4'(WAIT);

    arb_state_e    state_q, state_d;
    port_id_e      port_q, port_d;
    logic [3:0]    wait_q, wait_d;
    logic          we_q, we_d;
    logic          bmode_q, bmode_d;
    logic          misalign_q, misalign_d;
    logic          last_x_q, last_x_d;
    logic [1:0]    lane_q, lane_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic [31:0]   x_rdata_q, x_rdata_d;

    logic          cpu_req;
    logic          grant_x;
    logic          capture;
    logic [3:0]    fmt_be;
    logic [31:0]   fmt_wdata;
    logic [31:0]   fmt_rdata;

    // Only the word-address bits reach the memory; upper bits wrap
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:AW+2], d_addr[31:AW+2], x_addr[31:AW+2]};

    mem_lane_fmt u_lane_fmt (
        .lane       (lane_q),
        .bmode      (bmode_q),
        .wdata      (wdata_q),
        .mem_rdata  (mem_rdata),
        .be         (fmt_be),
        .lane_wdata (fmt_wdata),
        .lane_rdata (fmt_rdata)
    );

    // Arbitration: D beats IF; X and the CPU alternate under contention via last_x
    always_comb begin
        cpu_req = if_req | d_req;
        grant_x = x_req & (~cpu_req | ~last_x_q);
    end

    // Next-state: grant and latch in IDLE, count wait cycles in ACCESS
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        wait_d     = wait_q;
        we_d       = we_q;
        bmode_d    = bmode_q;
        misalign_d = misalign_q;
        last_x_d   = last_x_q;
        lane_d     = lane_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (x_req | cpu_req) begin
                    state_d  = StAccess;
                    wait_d   = WaitInit;
                    last_x_d = grant_x;
                    if (grant_x) begin
                        port_d     = PortX;
                        we_d       = x_we;
                        bmode_d    = 1'b0;
                        misalign_d = 1'b0;
                        lane_d     = x_addr[1:0];
                        addr_d     = x_addr[AW+1:2];
                        wdata_d    = x_wdata;
                    end else if (d_req) begin
                        port_d     = PortD;
                        we_d       = d_we;
                        bmode_d    = d_bmode;
                        misalign_d = ~d_bmode & (d_addr[1:0] != 2'b00);
                        lane_d     = d_addr[1:0];
                        addr_d     = d_addr[AW+1:2];
                        wdata_d    = d_wdata;
                    end else begin
                        port_d     = PortIf;
                        we_d       = 1'b0;
                        bmode_d    = 1'b0;
                        misalign_d = 1'b0;
                        lane_d     = if_addr[1:0];
                        addr_d     = if_addr[AW+1:2];
                        wdata_d    = 32'h0;
                    end
                end
            end
            StAccess: begin
                if (wait_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Load data is captured into the winner's register on the last ACCESS edge;
    // stores leave the read-data registers untouched
    always_comb begin
        capture    = (state_q == StAccess) && (wait_q == 4'd0) && !we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        x_rdata_d  = x_rdata_q;
        if (capture) begin
            unique case (port_q)
                PortIf:  if_rdata_d = fmt_rdata;
                PortD:   d_rdata_d  = fmt_rdata;
                PortX:   x_rdata_d  = fmt_rdata;
                default: ;
            endcase
        end
    end

    // State and latch registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            port_q     <= PortIf;
            wait_q     <= 4'd0;
            we_q       <= 1'b0;
            bmode_q    <= 1'b0;
            misalign_q <= 1'b0;
            last_x_q   <= 1'b1;
            lane_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
            x_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            wait_q     <= wait_d;
            we_q       <= we_d;
            bmode_q    <= bmode_d;
            misalign_q <= misalign_d;
            last_x_q   <= last_x_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            x_rdata_q  <= x_rdata_d;
        end
    end

    // Memory drive only in ACCESS; acks only in RESP
    always_comb begin
        mem_en    = (state_q == StAccess);
        mem_we    = mem_en & we_q;
        mem_be    = mem_en ? fmt_be : 4'b0000;
        mem_addr  = addr_q;
        mem_wdata = fmt_wdata;
        if_ack    = (state_q == StResp) && (port_q == PortIf);
        d_ack     = (state_q == StResp) && (port_q == PortD);
        x_ack     = (state_q == StResp) && (port_q == PortX);
        d_err     = d_ack & misalign_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        x_rdata   = x_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected responses
// from a transaction-level model; a negedge monitor pops and compares on acks.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 10;
    localparam int unsigned WAIT = 1;
    localparam int          Gap  = WAIT + 3;
    localparam int          Words = 1 << AW;

    typedef struct {
        int          port;   // 0 = IF, 1 = D, 2 = X
        bit          we;
        bit          bm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = 32'h0;
    logic [31:0]   if_rdata;
    logic          if_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic          d_bmode = 1'b0;
    logic [31:0]   d_addr = 32'h0;
    logic [31:0]   d_wdata = 32'h0;
    logic [31:0]   d_rdata;
    logic          d_ack;
    logic          d_err;
    logic          x_req = 1'b0;
    logic          x_we = 1'b0;
    logic [31:0]   x_addr = 32'h0;
    logic [31:0]   x_wdata = 32'h0;
    logic [31:0]   x_rdata;
    logic          x_ack;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .WAIT(WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_bmode   (d_bmode),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .x_req     (x_req),
        .x_we      (x_we),
        .x_addr    (x_addr),
        .x_wdata   (x_wdata),
        .x_rdata   (x_rdata),
        .x_ack     (x_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        return (i * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // Memory macro: synchronous read, byte-enabled write
    logic [31:0] mem [Words];
    initial begin
        for (int i = 0; i < Words; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                mem_rdata <= mem[mem_addr];
                for (int b = 0; b < 4; b++)
                    if (mem_we && mem_be[b]) mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents and grant history
    logic [31:0] ref_mem [Words];
    bit          last_x_m = 1'b1;
    txn_t        exp_q [$];

    function automatic int model_pick(bit ip, bit dp, bit xp);
        if (xp && (!(ip || dp) || !last_x_m)) begin
            last_x_m = 1'b1;
            return 2;
        end
        last_x_m = 1'b0;
        return dp ? 1 : 0;
    endfunction

    function automatic txn_t model_exec(txn_t t);
        int         w;
        logic [1:0] lane;
        logic [7:0] b;
        w       = int'(t.addr[AW+1:2]);
        lane    = t.addr[1:0];
        t.err   = (t.port == 1) && !t.bm && (lane != 2'd0);
        t.rdata = 32'h0;
        if (t.we) begin
            if (t.bm) ref_mem[w][8*lane +: 8] = t.wdata[7:0];
            else      ref_mem[w] = t.wdata;
        end else if (t.bm) begin
            b       = ref_mem[w][8*lane +: 8];
            t.rdata = {{24{b[7]}}, b};
        end else begin
            t.rdata = ref_mem[w];
        end
        return t;
    endfunction

    function automatic txn_t mk_fixed(int port, bit we, bit bm, logic [31:0] addr,
                                      logic [31:0] wdata);
        txn_t t;
        t.port = port; t.we = we; t.bm = bm; t.addr = addr; t.wdata = wdata;
        t.rdata = 32'h0; t.err = 1'b0;
        return t;
    endfunction

    function automatic txn_t mk_rand(int port);
        txn_t t;
        t = mk_fixed(port, (port != 0) && ($urandom_range(0, 1) == 1),
                     (port == 1) && ($urandom_range(0, 1) == 1),
                     ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                         | 32'($urandom_range(0, 3)),
                     $urandom);
        if (!t.bm && $urandom_range(0, 3) != 0) t.addr[1:0] = 2'b00;
        return t;
    endfunction

    // Monitor: pops the scoreboard on every ack, tracks expected read-data registers
    logic [31:0] exp_rd [3];
    int          cyc = 0;
    int          last_ack_cyc = -100;
    bit          strict = 1'b0;
    int          strict_cnt = 0;
    always @(negedge clk) begin
        int   port;
        int   n;
        txn_t t;
        cyc++;
        if (rst) begin
            n = int'(if_ack) + int'(d_ack) + int'(x_ack);
            check("d_err_only_with_ack", 32'(d_err & ~d_ack), 32'd0);
            if (n != 0) begin
                check("one_ack_at_a_time", 32'(n), 32'd1);
                check("mem_en_low_in_resp", 32'(mem_en), 32'd0);
                if (strict) begin
                    if (strict_cnt > 0) check("ack_spacing", 32'(cyc - last_ack_cyc), 32'(Gap));
                    strict_cnt++;
                end else begin
                    check("ack_gap_min", 32'(cyc - last_ack_cyc >= Gap), 32'd1);
                end
                port = if_ack ? 0 : (d_ack ? 1 : 2);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: port %0d acked with nothing expected", port);
                end else begin
                    t = exp_q.pop_front();
                    check("ack_port", 32'(port), 32'(t.port));
                    if (t.port == 1) check("d_err", 32'(d_err), 32'(t.err));
                    if (!t.we) exp_rd[t.port] = t.rdata;
                end
                last_ack_cyc = cyc;
            end
            check("if_rdata", if_rdata, exp_rd[0]);
            check("d_rdata", d_rdata, exp_rd[1]);
            check("x_rdata", x_rdata, exp_rd[2]);
        end else begin
            for (int i = 0; i < 3; i++) exp_rd[i] = 32'h0;
            last_ack_cyc = -100;
        end
    end

    task automatic drive(input txn_t t);
        case (t.port)
            0: begin if_addr = t.addr; if_req = 1'b1; end
            1: begin
                d_we = t.we; d_bmode = t.bm; d_addr = t.addr; d_wdata = t.wdata; d_req = 1'b1;
            end
            default: begin x_we = t.we; x_addr = t.addr; x_wdata = t.wdata; x_req = 1'b1; end
        endcase
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while ((if_req || d_req || x_req) && c < 100) begin
            @(negedge clk);
            if (if_ack) if_req = 1'b0;
            if (d_ack)  d_req  = 1'b0;
            if (x_ack)  x_req  = 1'b0;
            c++;
        end
        if (if_req || d_req || x_req) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out waiting for ack", name);
            if_req = 1'b0; d_req = 1'b0; x_req = 1'b0;
        end
    endtask

    // Raise a set of requests together; the model orders the grants
    task automatic run_round(input bit ui, input bit ud, input bit ux, input txn_t ti,
                             input txn_t td, input txn_t tx, input string name);
        bit pi, pd, px;
        int p;
        @(negedge clk);
        if (ui) drive(ti);
        if (ud) drive(td);
        if (ux) drive(tx);
        pi = ui; pd = ud; px = ux;
        while (pi || pd || px) begin
            p = model_pick(pi, pd, px);
            case (p)
                0:       begin exp_q.push_back(model_exec(ti)); pi = 1'b0; end
                1:       begin exp_q.push_back(model_exec(td)); pd = 1'b0; end
                default: begin exp_q.push_back(model_exec(tx)); px = 1'b0; end
            endcase
        end
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t, ti, td, tx;
        bit   ui, ud, ux;
        int   p, acks, c;
        for (int i = 0; i < Words; i++) ref_mem[i] = init_word(i);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_if_ack", 32'(if_ack), 32'd0);
        check("reset_d_ack", 32'(d_ack), 32'd0);
        check("reset_x_ack", 32'(x_ack), 32'd0);
        check("reset_d_err", 32'(d_err), 32'd0);
        check("reset_mem_en", 32'(mem_en), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_be", 32'(mem_be), 32'd0);
        check("reset_d_rdata", d_rdata, 32'd0);
        rst = 1'b1;

        // Word load latency: mem_en cycles 1-2, ack cycle 3
        t = mk_fixed(1, 1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        drive(t);
        p = model_pick(1'b0, 1'b1, 1'b0);
        exp_q.push_back(model_exec(t));
        @(negedge clk);
        check("lat_c1_mem_en", 32'(mem_en), 32'd1);
        check("lat_c1_mem_addr", 32'(mem_addr), 32'd4);
        check("lat_c1_d_ack", 32'(d_ack), 32'd0);
        @(negedge clk);
        check("lat_c2_mem_en", 32'(mem_en), 32'd1);
        check("lat_c2_d_ack", 32'(d_ack), 32'd0);
        @(negedge clk);
        check("lat_c3_d_ack", 32'(d_ack), 32'd1);
        check("lat_c3_d_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        @(negedge clk);
        check("lat_c4_ack_one_cycle", 32'(d_ack), 32'd0);

        // Contention among all three requesters
        run_round(1'b1, 1'b1, 1'b0, mk_rand(0), mk_rand(1), mk_rand(2), "if_d_conflict");
        run_round(1'b1, 1'b1, 1'b1, mk_rand(0), mk_rand(1), mk_rand(2), "three_way");

        // Byte store to lane 3, then sign-extended byte load
        t = mk_fixed(1, 1'b1, 1'b1, 32'h23, 32'h12345680);
        @(negedge clk);
        drive(t);
        p = model_pick(1'b0, 1'b1, 1'b0);
        exp_q.push_back(model_exec(t));
        @(negedge clk);
        check("sb_mem_be", 32'(mem_be), 32'h8);
        check("sb_mem_wdata", mem_wdata, 32'h80808080);
        check("sb_mem_we", 32'(mem_we), 32'd1);
        check("sb_mem_addr", 32'(mem_addr), 32'd8);
        wait_done("sb");
        td = mk_fixed(1, 1'b0, 1'b1, 32'h23, 32'h0);
        run_round(1'b0, 1'b1, 1'b0, mk_rand(0), td, mk_rand(2), "lb");
        check("lb_d_rdata", d_rdata, 32'hFFFFFF80);

        // Misaligned word load flags d_err; the next aligned load does not
        td = mk_fixed(1, 1'b0, 1'b0, 32'h12, 32'h0);
        run_round(1'b0, 1'b1, 1'b0, mk_rand(0), td, mk_rand(2), "lw_misaligned");
        td = mk_fixed(1, 1'b0, 1'b0, 32'h14, 32'h0);
        run_round(1'b0, 1'b1, 1'b0, mk_rand(0), td, mk_rand(2), "lw_aligned");

        // IF and X held continuously: strict alternation at fixed spacing
        ti = mk_rand(0);
        tx = mk_rand(2);
        @(negedge clk);
        drive(ti);
        drive(tx);
        strict_cnt = 0;
        strict = 1'b1;
        for (int k = 0; k < 6; k++) begin
            p = model_pick(1'b1, 1'b0, 1'b1);
            exp_q.push_back(model_exec(p == 2 ? tx : ti));
        end
        acks = 0;
        c = 0;
        while (acks < 6 && c < 100) begin
            @(negedge clk);
            if (if_ack || x_ack) acks++;
            c++;
        end
        if_req = 1'b0;
        x_req = 1'b0;
        strict = 1'b0;
        check("alternation_ack_count", 32'(acks), 32'd6);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            do begin
                ui = 1'($urandom_range(0, 1));
                ud = 1'($urandom_range(0, 1));
                ux = 1'($urandom_range(0, 1));
            end while (!(ui || ud || ux));
            run_round(ui, ud, ux, mk_rand(0), mk_rand(1), mk_rand(2), "random_round");
        end

        // Reset during a store's ACCESS: memory drive drops at once, no ack
        t = mk_fixed(1, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D);
        @(negedge clk);
        drive(t);
        @(negedge clk);
        check("pre_reset_mem_en", 32'(mem_en), 32'd1);
        check("pre_reset_mem_we", 32'(mem_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_mem_en_drop", 32'(mem_en), 32'd0);
        check("rst_mem_we_drop", 32'(mem_we), 32'd0);
        check("rst_mem_be_drop", 32'(mem_be), 32'd0);
        exp_q.delete();
        last_x_m = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_d_ack", 32'(d_ack), 32'd0);
        end
        rst = 1'b1;
        p = model_pick(1'b0, 1'b1, 1'b0);
        exp_q.push_back(model_exec(t));
        wait_done("store_after_reset");
        td = mk_fixed(1, 1'b0, 1'b0, 32'h40, 32'h0);
        run_round(1'b0, 1'b1, 1'b0, mk_rand(0), td, mk_rand(2), "load_after_reset");
        run_round(1'b1, 1'b0, 1'b1, mk_rand(0), mk_rand(1), mk_rand(2), "first_conflict");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
